// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int ADDR_W = 32;
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  // Instruction memory is word addressed; the low two address bits are dropped.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~(ADDR_W'(3));
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencing: IDLE/REQ/WAIT/HOLD state machine plus the discard flag
// that drops a response whose request was overtaken by a flush.
module fetch_ctrl
  import fetch_unit_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic stall_i,
  input  logic flush_i,
  input  logic mem_ready_i,
  input  logic mem_valid_i,
  output logic mem_req_o,
  output logic load_addr_o,
  output logic accept_o,
  output logic inst_valid_next_o
);

  fetch_state_t state_reg, state_next;
  logic         discard_reg, discard_next;
  logic         mem_req_reg;
  logic         load_addr;
  logic         accept;

  // Next-state, discard and strobe decode.
  always_comb begin
    state_next   = state_reg;
    discard_next = discard_reg;
    load_addr    = 1'b0;
    accept       = 1'b0;
    if (!start_i) begin
      state_next   = ST_IDLE;
      discard_next = 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          state_next = ST_REQ;
          load_addr  = 1'b1;
        end
        ST_REQ: begin
          if (flush_i && mem_ready_i) begin
            // The stale request was already accepted: wait for its response,
            // drop it, then refetch from the redirected PC.
            state_next   = ST_WAIT;
            discard_next = 1'b1;
          end else if (flush_i) begin
            load_addr = 1'b1;
          end else if (mem_ready_i) begin
            state_next = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_valid_i) begin
            if (flush_i || discard_reg) begin
              state_next   = ST_REQ;
              discard_next = 1'b0;
              load_addr    = 1'b1;
            end else begin
              state_next = ST_HOLD;
              accept     = 1'b1;
            end
          end else if (flush_i) begin
            discard_next = 1'b1;
          end
        end
        ST_HOLD: begin
          if (flush_i || !stall_i) begin
            state_next = ST_REQ;
            load_addr  = 1'b1;
          end
        end
        default: begin
          state_next   = ST_IDLE;
          discard_next = 1'b0;
        end
      endcase
    end
  end

  // State, discard flag and registered request strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      discard_reg <= 1'b0;
      mem_req_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      discard_reg <= discard_next;
      mem_req_reg <= (state_next == ST_REQ);
    end
  end

  assign mem_req_o         = mem_req_reg;
  assign load_addr_o       = load_addr & ~rst_i;
  assign accept_o          = accept & ~rst_i;
  // HOLD is only entered by accepting a response, so it doubles as the valid flag.
  assign inst_valid_next_o = (state_next == ST_HOLD);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word read at a time and presents the
// returned instruction with its address to the IF/ID stage.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic              mem_valid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  output logic              pc_advance_o
);

  logic              load_addr;
  logic              accept;
  logic              inst_valid_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       inst_reg;
  logic [ADDR_W-1:0] inst_pc_reg;
  logic              inst_valid_reg;

  fetch_ctrl u_ctrl (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .stall_i           (stall_i),
    .flush_i           (flush_i),
    .mem_ready_i       (mem_ready_i),
    .mem_valid_i       (mem_valid_i),
    .mem_req_o         (mem_req_o),
    .load_addr_o       (load_addr),
    .accept_o          (accept),
    .inst_valid_next_o (inst_valid_next)
  );

  // Address capture on REQ entry and instruction capture on accepted response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_reg       <= '0;
      inst_reg       <= NOP;
      inst_pc_reg    <= '0;
      inst_valid_reg <= 1'b0;
    end else begin
      if (load_addr) begin
        addr_reg <= word_align(pc_i);
      end
      if (accept) begin
        inst_reg    <= mem_rdata_i;
        inst_pc_reg <= addr_reg;
      end
      inst_valid_reg <= inst_valid_next;
    end
  end

  assign mem_addr_o   = addr_reg;
  assign inst_o       = inst_reg;
  assign inst_pc_o    = inst_pc_reg;
  assign inst_valid_o = inst_valid_reg;
  assign pc_advance_o = accept;

endmodule
